// File: rtl/serial_rx_checker_if.sv
// Result port of the serial receive checker: received word plus per-frame
// error information, transferred on out_valid & out_ready.
interface serial_rx_checker_if #(
    parameter int DATA_W = 32
);
    localparam int ERR_W = $clog2(DATA_W) + 1;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ERR_W-1:0]  out_err_bits;
    logic              out_mismatch;

    modport master (
        output out_valid,
        output out_data,
        output out_err_bits,
        output out_mismatch,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_err_bits,
        input  out_mismatch,
        output out_ready
    );
endinterface

// File: rtl/serial_rx_checker.sv
// Receive/compare side of the link self test: rebuilds MSB-first serial words,
// compares them with the expected word and keeps saturating statistics.
module serial_rx_checker #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                frame_start,
    input  logic [DATA_W-1:0]   expected,
    input  logic                serial_in,
    input  logic                clear,
    serial_rx_checker_if.master out_if,
    output logic                busy,
    output logic [CNT_W-1:0]    frame_cnt,
    output logic [CNT_W-1:0]    err_frame_cnt,
    output logic [CNT_W-1:0]    bit_err_cnt,
    output logic                overflow,
    output logic                sync_err
);
    localparam int ERR_W = $clog2(DATA_W) + 1;
    localparam int BC_W  = $clog2(DATA_W);
    localparam int SUM_W = ((CNT_W > ERR_W) ? CNT_W : ERR_W) + 1;
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_W - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    function automatic logic [ERR_W-1:0] popcount(input logic [DATA_W-1:0] v);
        logic [ERR_W-1:0] n;
        n = '0;
        for (int i = 0; i < DATA_W; i++) begin
            n = n + ERR_W'(v[i]);
        end
        return n;
    endfunction

    // Widened sum so an increment larger than the counter range still clamps.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [ERR_W-1:0] b);
        logic [SUM_W-1:0] s;
        s = SUM_W'(a) + SUM_W'(b);
        if (s > SUM_W'({CNT_W{1'b1}})) begin
            return {CNT_W{1'b1}};
        end
        return s[CNT_W-1:0];
    endfunction

    state_t              state_q, state_d;
    logic [BC_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_W-2:0]   shift_q, shift_d;
    logic [DATA_W-1:0]   exp_q, exp_d;
    logic                valid_q, valid_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [ERR_W-1:0]    errb_q, errb_d;
    logic                mism_q, mism_d;
    logic [CNT_W-1:0]    fcnt_q, fcnt_d;
    logic [CNT_W-1:0]    efcnt_q, efcnt_d;
    logic [CNT_W-1:0]    bcnt_q, bcnt_d;
    logic                ovf_q, ovf_d;
    logic                sync_q, sync_d;

    logic [DATA_W-1:0]   word;
    logic [ERR_W-1:0]    err;
    logic                complete;
    logic                slot_free;

    assign word      = {shift_q, serial_in};
    assign err       = popcount(word ^ exp_q);
    assign complete  = (state_q == SHIFT) && (bit_cnt_q == LAST_BIT);
    assign slot_free = !valid_q || out_if.out_ready;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        exp_d     = exp_q;
        valid_d   = valid_q;
        data_d    = data_q;
        errb_d    = errb_q;
        mism_d    = mism_q;
        fcnt_d    = fcnt_q;
        efcnt_d   = efcnt_q;
        bcnt_d    = bcnt_q;
        ovf_d     = ovf_q;
        sync_d    = sync_q;

        if (valid_q && out_if.out_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    exp_d     = expected;
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                shift_d = {shift_q[DATA_W-3:0], serial_in};
                if (complete) begin
                    fcnt_d = sat_add(fcnt_q, ERR_W'(1));
                    bcnt_d = sat_add(bcnt_q, err);
                    if (err != '0) begin
                        efcnt_d = sat_add(efcnt_q, ERR_W'(1));
                    end
                    // A full slot that is not draining this cycle drops the new word.
                    if (slot_free) begin
                        valid_d = 1'b1;
                        data_d  = word;
                        errb_d  = err;
                        mism_d  = (err != '0);
                    end else begin
                        ovf_d = 1'b1;
                    end
                    if (frame_start) begin
                        exp_d     = expected;
                        bit_cnt_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (frame_start) begin
                    sync_d    = 1'b1;
                    exp_d     = expected;
                    bit_cnt_d = '0;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (clear) begin
            fcnt_d  = '0;
            efcnt_d = '0;
            bcnt_d  = '0;
            ovf_d   = 1'b0;
            sync_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            exp_q     <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            errb_q    <= '0;
            mism_q    <= 1'b0;
            fcnt_q    <= '0;
            efcnt_q   <= '0;
            bcnt_q    <= '0;
            ovf_q     <= 1'b0;
            sync_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            exp_q     <= exp_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            errb_q    <= errb_d;
            mism_q    <= mism_d;
            fcnt_q    <= fcnt_d;
            efcnt_q   <= efcnt_d;
            bcnt_q    <= bcnt_d;
            ovf_q     <= ovf_d;
            sync_q    <= sync_d;
        end
    end

    assign busy                = (state_q == SHIFT);
    assign out_if.out_valid    = valid_q;
    assign out_if.out_data     = data_q;
    assign out_if.out_err_bits = errb_q;
    assign out_if.out_mismatch = mism_q;
    assign frame_cnt           = fcnt_q;
    assign err_frame_cnt       = efcnt_q;
    assign bit_err_cnt         = bcnt_q;
    assign overflow            = ovf_q;
    assign sync_err            = sync_q;
endmodule

// File: tb/tb_serial_rx_checker.sv
// Bench for serial_rx_checker: directed frame table, corner sequences and
// random traffic against a queue-based frame model; a CNT_W=4 copy checks saturation.
module tb_serial_rx_checker;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_start;
    logic [31:0] expected;
    logic        serial_in;
    logic        clear;
    logic        out_ready;

    always #5 clk = ~clk;

    serial_rx_checker_if #(.DATA_W(32)) bus16 ();
    serial_rx_checker_if #(.DATA_W(32)) bus4 ();
    assign bus16.out_ready = out_ready;
    assign bus4.out_ready  = out_ready;

    logic        busy16, ovf16, sync16, busy4, ovf4, sync4;
    logic [15:0] fc16, efc16, bec16;
    logic [3:0]  fc4, efc4, bec4;

    serial_rx_checker #(.DATA_W(32), .CNT_W(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .expected(expected),
        .serial_in(serial_in), .clear(clear), .out_if(bus16), .busy(busy16),
        .frame_cnt(fc16), .err_frame_cnt(efc16), .bit_err_cnt(bec16),
        .overflow(ovf16), .sync_err(sync16));

    serial_rx_checker #(.DATA_W(32), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .expected(expected),
        .serial_in(serial_in), .clear(clear), .out_if(bus4), .busy(busy4),
        .frame_cnt(fc4), .err_frame_cnt(efc4), .bit_err_cnt(bec4),
        .overflow(ovf4), .sync_err(sync4));

    int n_chk;
    int n_fail;

    // Model: bits collected for the frame in progress, held result, true counts.
    bit          mq[$];
    bit          m_busy;
    logic [31:0] m_exp;
    bit          m_valid;
    logic [31:0] m_data;
    int          m_errb;
    int          m_fc, m_efc, m_bec;
    bit          m_ovf, m_sync;

    function automatic int sat(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic model_reset();
        mq.delete();
        m_busy = 0; m_exp = '0; m_valid = 0; m_data = '0; m_errb = 0;
        m_fc = 0; m_efc = 0; m_bec = 0; m_ovf = 0; m_sync = 0;
    endtask

    task automatic model_step();
        bit          xfer;
        bit          done;
        logic [31:0] w;
        int          e;
        xfer = m_valid && out_ready;
        done = 0;
        if (m_busy) begin
            if (mq.size() == 31) begin
                w = '0;
                foreach (mq[i]) w = {w[30:0], mq[i]};
                w = {w[30:0], serial_in};
                e = $countones(w ^ m_exp);
                m_fc++;
                if (e != 0) m_efc++;
                m_bec += e;
                if (!m_valid || out_ready) begin
                    m_data = w; m_errb = e; m_valid = 1;
                end else begin
                    m_ovf = 1;
                end
                done = 1;
                mq.delete();
                if (frame_start) m_exp = expected;
                else m_busy = 0;
            end else if (frame_start) begin
                m_sync = 1; m_exp = expected; mq.delete();
            end else begin
                mq.push_back(serial_in);
            end
        end else if (frame_start) begin
            m_busy = 1; m_exp = expected; mq.delete();
        end
        if (!done && xfer) m_valid = 0;
        if (clear) begin
            m_fc = 0; m_efc = 0; m_bec = 0; m_ovf = 0; m_sync = 0;
        end
    endtask

    task automatic compare_all();
        chk("busy", busy16, m_busy);
        chk("out_valid", bus16.out_valid, m_valid);
        chk("out_data", bus16.out_data, m_data);
        chk("out_err_bits", bus16.out_err_bits, m_errb);
        chk("out_mismatch", bus16.out_mismatch, m_errb != 0);
        chk("frame_cnt", fc16, sat(m_fc, 65535));
        chk("err_frame_cnt", efc16, sat(m_efc, 65535));
        chk("bit_err_cnt", bec16, sat(m_bec, 65535));
        chk("overflow", ovf16, m_ovf);
        chk("sync_err", sync16, m_sync);
        chk("c4_out_valid", bus4.out_valid, m_valid);
        chk("c4_frame_cnt", fc4, sat(m_fc, 15));
        chk("c4_err_frame_cnt", efc4, sat(m_efc, 15));
        chk("c4_bit_err_cnt", bec4, sat(m_bec, 15));
    endtask

    task automatic cyc(input bit fs, input logic [31:0] e, input bit s, input bit clr, input bit rdy);
        frame_start = fs; expected = e; serial_in = s; clear = clr; out_ready = rdy;
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        #1;
        compare_all();
    endtask

    task automatic start(input logic [31:0] e, input bit rdy);
        cyc(1'b1, e, 1'($urandom), 1'b0, rdy);
    endtask

    task automatic send_bits(input logic [31:0] w, input bit rdy, input bit nfs, input logic [31:0] ne);
        for (int i = 31; i >= 0; i--) begin
            cyc((i == 0) ? nfs : 1'b0, (i == 0) ? ne : $urandom, w[i], 1'b0, rdy);
        end
    endtask

    typedef struct {
        logic [31:0] word;
        logic [31:0] exp;
        int          errb;
        int          fc;
        int          efc;
        int          bec;
    } vec_t;

    vec_t        tbl[5];
    logic [31:0] bb[3];

    initial begin
        n_chk = 0; n_fail = 0;
        model_reset();
        rst_n = 1'b0; frame_start = 0; expected = '0; serial_in = 0; clear = 0; out_ready = 0;

        tbl[0] = '{32'hA5A50F0F, 32'hA5A50F0F, 0,  1, 0, 0};
        tbl[1] = '{32'hA5A50F0F, 32'hA5A50F0E, 1,  2, 1, 1};
        tbl[2] = '{32'hFFFFFFFF, 32'h00000000, 32, 3, 2, 33};
        tbl[3] = '{32'h12345678, 32'h9235567B, 4,  4, 3, 37};
        tbl[4] = '{32'h00000000, 32'h00000000, 0,  5, 3, 37};

        // Reset held with random inputs
        for (int i = 0; i < 6; i++) begin
            cyc(1'($urandom), $urandom, 1'($urandom), 1'($urandom), 1'($urandom));
        end
        rst_n = 1'b1;
        cyc(0, '0, 0, 0, 1);
        chk("rst_busy", busy16, 0);
        chk("rst_valid", bus16.out_valid, 0);

        // Directed frame table
        for (int i = 0; i < 5; i++) begin
            start(tbl[i].exp, 1'b1);
            send_bits(tbl[i].word, 1'b1, 1'b0, '0);
            chk("tbl_valid", bus16.out_valid, 1);
            chk("tbl_data", bus16.out_data, tbl[i].word);
            chk("tbl_err_bits", bus16.out_err_bits, tbl[i].errb);
            chk("tbl_mismatch", bus16.out_mismatch, tbl[i].errb != 0);
            chk("tbl_frame_cnt", fc16, tbl[i].fc);
            chk("tbl_err_frame_cnt", efc16, tbl[i].efc);
            chk("tbl_bit_err_cnt", bec16, tbl[i].bec);
            cyc(0, '0, 0, 0, 1);
        end

        // Three back-to-back frames
        cyc(0, '0, 0, 1, 1);
        bb[0] = 32'hDEADBEEF; bb[1] = 32'h0123_4567; bb[2] = 32'hCAFEF00D;
        start(bb[0], 1'b1);
        for (int i = 0; i < 3; i++) begin
            send_bits(bb[i], 1'b1, i < 2, (i < 2) ? bb[i+1] : 32'h0);
            chk("b2b_valid", bus16.out_valid, 1);
            chk("b2b_data", bus16.out_data, bb[i]);
            chk("b2b_busy", busy16, i < 2);
        end
        chk("b2b_frame_cnt", fc16, 3);
        chk("b2b_sync_err", sync16, 0);
        cyc(0, '0, 0, 0, 1);

        // Output held while consumer stalls
        cyc(0, '0, 0, 1, 0);
        start(32'h0, 1'b0);
        send_bits(32'h1111_2222, 1'b0, 1'b1, 32'h0);
        send_bits(32'h3333_4444, 1'b0, 1'b0, 32'h0);
        chk("ovf_valid", bus16.out_valid, 1);
        chk("ovf_data", bus16.out_data, 32'h1111_2222);
        chk("ovf_flag", ovf16, 1);
        chk("ovf_frame_cnt", fc16, 2);
        cyc(0, '0, 0, 0, 1);
        chk("ovf_drain_valid", bus16.out_valid, 0);
        cyc(0, '0, 0, 1, 1);
        chk("clr_frame_cnt", fc16, 0);
        chk("clr_overflow", ovf16, 0);

        // frame_start at bit 10 aborts the frame in progress
        start(32'h5555_5555, 1'b1);
        for (int i = 0; i < 10; i++) cyc(0, '0, 1'($urandom), 0, 1);
        cyc(1, 32'h8000_0001, 1'($urandom), 0, 1);
        chk("abort_sync_err", sync16, 1);
        chk("abort_valid", bus16.out_valid, 0);
        chk("abort_frame_cnt", fc16, 0);
        send_bits(32'h8000_0001, 1'b1, 1'b0, '0);
        chk("abort_new_valid", bus16.out_valid, 1);
        chk("abort_new_data", bus16.out_data, 32'h8000_0001);
        chk("abort_new_cnt", fc16, 1);
        cyc(0, '0, 0, 1, 1);

        // Reset mid-frame discards the partial frame
        start(32'hFFFF_0000, 1'b1);
        for (int i = 0; i < 5; i++) cyc(0, '0, 1'($urandom), 0, 1);
        #2 rst_n = 1'b0;
        model_reset();
        #1 compare_all();
        cyc(0, '0, 1, 0, 1);
        rst_n = 1'b1;
        for (int i = 0; i < 35; i++) cyc(0, '0, 1'($urandom), 0, 1);
        chk("rst_mid_valid", bus16.out_valid, 0);

        // Twenty erroneous frames saturate the narrow counters
        cyc(0, '0, 0, 1, 1);
        begin
            logic [31:0] w;
            w = $urandom;
            start(w ^ 32'h1, 1'b1);
            for (int i = 0; i < 20; i++) begin
                logic [31:0] nw;
                nw = $urandom;
                send_bits(w, 1'b1, i < 19, nw ^ 32'h1);
                w = nw;
            end
        end
        chk("sat4_err_frame_cnt", efc4, 15);
        chk("sat4_frame_cnt", fc4, 15);
        chk("sat16_err_frame_cnt", efc16, 20);
        cyc(0, '0, 0, 0, 1);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            bit fs;
            fs = ($urandom_range(0, 59) == 0);
            if (m_busy && mq.size() == 31) fs = 1'($urandom);
            cyc(fs, $urandom, 1'($urandom), $urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_rx_checker.md
# serial_rx_checker

Downstream partner of the 32-bit self-test serializer. It samples the MSB-first serial stream, rebuilds each 32-bit word and compares it against the expected word supplied at frame start. It presents the received word with per-frame error information on a valid/ready port and keeps saturating frame and error counters. It is the receive/compare side of the link self test.

## Interface
- DATA_W, 32: word width; serial frame length in clocks.
- CNT_W, 16: width of the saturating statistics counters.

- clk  in  1  clock; all sampling is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-cycle pulse, asserted in the same cycle the serializer's load enable is asserted.
- expected  in  DATA_W  reference word; latched when frame_start is sampled.
- serial_in  in  1  serial bit stream, MSB first.
- clear  in  1  synchronous clear of counters and sticky flags.
- out_ready  in  1  consumer accepts the result word.
- busy  out  1  a frame is being received.
- out_valid  out  1  result word held.
- out_data  out  DATA_W  received word.
- out_err_bits  out  $clog2(DATA_W)+1  popcount(out_data ^ expected).
- out_mismatch  out  1  out_err_bits != 0.
- frame_cnt  out  CNT_W  completed frames, saturating.
- err_frame_cnt  out  CNT_W  completed frames with a mismatch, saturating.
- bit_err_cnt  out  CNT_W  accumulated bit errors, saturating.
- overflow  out  1  sticky: a frame completed while out_valid=1 and out_ready=0.
- sync_err  out  1  sticky: frame_start arrived mid-frame.

## Operation
- States: IDLE, SHIFT. A bit counter (0..DATA_W-1) and a shift register run in SHIFT. busy = (state == SHIFT).
- IDLE, frame_start=1: latch expected, clear bit counter, go to SHIFT. In IDLE, serial_in is ignored.
- SHIFT: every clock, shift serial_in into the LSB and increment the bit counter.
- At bit counter DATA_W-1, the frame completes:
  - word = {shift[DATA_W-2:0], serial_in}; err = popcount(word ^ latched expected).
  - frame_cnt increments. If err != 0, err_frame_cnt increments. bit_err_cnt increases by err.
  - All three counters saturate at all-ones and never wrap.
  - If the output slot is free, or freed this cycle (out_valid & out_ready), load out_data, out_err_bits and out_mismatch, and set out_valid.
  - Otherwise the new word is dropped, the held word is unchanged, and overflow is set. The counters are still updated.
  - If frame_start=1 in the same cycle, this is a legal back-to-back frame: latch the new expected and stay in SHIFT with the counter at 0. Otherwise go to IDLE.
- frame_start in SHIFT at any bit counter value other than DATA_W-1:
  - Abort the current frame: no output, no counter change.
  - Set sync_err, latch the new expected, and restart at bit counter 0.
- Handshake: the word transfers on out_valid & out_ready. out_valid stays high and out_data stays stable until that transfer.
- clear:
  - Zeroes the counters, overflow and sync_err.
  - Does not affect the FSM, the shift register or the output slot.
  - If clear coincides with a completion, clear wins: the counters read 0 afterwards and that frame's output is still delivered.

## Timing
- Reset values: state IDLE; busy, out_valid, out_mismatch, overflow, sync_err = 0; out_data, out_err_bits and all counters = 0.
- Reset mid-frame discards the partial frame; no output is produced.
- With frame_start sampled at edge k, bits are sampled at edges k+1 … k+32, MSB at k+1 and LSB at k+32.
- out_valid, the counters and overflow update at edge k+32. The result is visible in cycle k+32.
- Minimum frame period is 32 clocks (frame_start at k, k+32, k+64 …), which gives continuous throughput.
- out_valid & out_ready at edge k+32 together with a completion gives a same-edge replace.

## Test plan
- Reset: hold rst_n=0 with random inputs → every output is 0; release → busy=0 and out_valid=0.
- Word 0xA5A50F0F serialized, expected=0xA5A50F0F, out_ready=1 → at edge k+32: out_valid=1, out_data=0xA5A50F0F, out_err_bits=0, frame_cnt=1, err_frame_cnt=0.
- Error counting, expected=0xA5A50F0E → out_err_bits=1, out_mismatch=1. Next frame sends 0xFFFFFFFF with expected 0 → out_err_bits=32. Totals: bit_err_cnt=33, err_frame_cnt=2.
- Three back-to-back frames (frame_start every 32 clocks), out_ready=1 → three valid words in order, frame_cnt=3, sync_err=0, busy stays high continuously.
- out_ready=0 for two frames → first word held unchanged, overflow=1, frame_cnt=2. Then out_ready=1 → first word transfers. clear → counters=0 and overflow=0.
- frame_start re-asserted at bit 10 → sync_err=1, no output for the aborted frame; the new frame completes 32 clocks after the second frame_start. Also run with CNT_W=4 and 20 erroneous frames → err_frame_cnt saturates at 15.
